// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the MEM stage and a word-organised
// data memory. It takes one byte/half/word request at a time. Sub-word stores
// are done as read-modify-write. Load data comes back sign- or zero-extended
// with a one-cycle response pulse.
//
// Optional feature: define LSU_BOUNDS_CHECK_EN to reject any request whose
// address bits above the memory range are nonzero (resp_err, no access).
// Without it, those upper address bits are ignored and addresses wrap.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req_valid/ready request handshake (ready only in IDLE, not in reset)
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned    loads: 1 = zero-extend, 0 = sign-extend
//   req_addr        byte address
//   req_wdata       right-justified store data
//   resp_valid      one-cycle completion pulse
//   resp_rdata      extended load data (0 for stores and errors)
//   resp_err        misaligned/out-of-range request; no memory access done
//   dm_we           memory write enable
//   mem_addr        memory word address
//   mem_wd          memory write data
//   mem_rd          memory read data, combinational from mem_addr
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dm_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              state_q;
  logic                we_q;
  logic                uns_q;
  logic [1:0]          size_q;
  logic [1:0]          off_q;
  logic [15:0]         wdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wd_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [31:0]         resp_rdata_q;

  logic                misaligned;
  logic                out_of_range;
  logic                req_err;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         ld_ext;
  logic [31:0]         lane_mask;
  logic [31:0]         st_merged;

  assign req_ready  = (state_q == IDLE) & ~rst;
  assign dm_we      = (state_q == WR) & ~rst;
  assign mem_addr   = mem_addr_q;
  assign mem_wd     = mem_wd_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

`ifdef LSU_BOUNDS_CHECK_EN
  assign out_of_range = |(req_addr >> (ADDR_W + 2));
`else
  logic unused_upper_addr;
  assign unused_upper_addr = ^(req_addr >> (ADDR_W + 2));
  assign out_of_range      = 1'b0;
`endif

  assign req_err = misaligned | out_of_range;

  // Lane selection and extension work straight off mem_rd at the end of RD.
  // The registered result takes the place of a separate read buffer.
  always_comb begin
    rd_byte = '0;
    case (off_q)
      2'd0:    rd_byte = mem_rd[7:0];
      2'd1:    rd_byte = mem_rd[15:8];
      2'd2:    rd_byte = mem_rd[23:16];
      default: rd_byte = mem_rd[31:24];
    endcase
    rd_half = off_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    ld_ext  = mem_rd;
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   ld_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ld_ext = mem_rd;
    endcase
  end

  // Read-modify-write merge: replace the addressed lane of the current word.
  always_comb begin
    lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    st_merged = (mem_rd & ~(lane_mask << {off_q, 3'b000}))
              | (({16'h0, wdata_q} & lane_mask) << {off_q, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata[15:0];
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              mem_addr_q <= req_addr[ADDR_W+1:2];
              if (req_we && (req_size == 2'b10)) begin
                mem_wd_q <= req_wdata;
                state_q  <= WR;
              end else begin
                state_q  <= RD;
              end
            end
          end
        end
        RD: begin
          if (we_q) begin
            mem_wd_q <= st_merged;
            state_q  <= WR;
          end else begin
            resp_rdata_q <= ld_ext;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        default: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

endmodule
